// File: rtl/up_counter_if.sv
// up_counter_if: groups the control and status signals of the interval timer.
// The master side (software/bus bridge) drives start and load.
// The slave side (the counter) returns count, done and busy.
// WIDTH must match the WIDTH of the up_counter instance that uses it.
interface up_counter_if #(
  parameter int unsigned WIDTH = 32'd16
);
  logic             start;
  logic [WIDTH-1:0] load;
  logic [WIDTH-1:0] count;
  logic             done;
  logic             busy;

  modport master (
    output start,
    output load,
    input  count,
    input  done,
    input  busy
  );

  modport slave (
    input  start,
    input  load,
    output count,
    output done,
    output busy
  );
endinterface

// File: rtl/up_counter.sv
// up_counter: general-purpose interval timer.
// While start is high the counter runs from its held value up to a limit.
// The limit is latched from load on each IDLE->RUN transition.
// At the limit the counter wraps to 0 and pulses done for one cycle.
// Dropping start pauses the count; a later start resumes from the held value.
//
// Build option: define UPCOUNTER_ONESHOT_EN to select one-shot behaviour.
// In that build, reaching the limit holds count there, pulses done once and
// parks in HALT until start drops. Dropping start returns to IDLE with
// count cleared.
//
// Reset: rst_n is synchronous and active HIGH despite its name.
module up_counter #(
  parameter int unsigned WIDTH = 32'd16
) (
  input  logic         clk,
  input  logic         rst_n,
  up_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Registered state.
  state_t           state_r;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] limit_r;
  logic             done_r;
  logic             busy_r;

  // Next-state values.
  state_t           state_next_s;
  logic [WIDTH-1:0] count_next_s;
  logic [WIDTH-1:0] limit_next_s;
  logic             done_next_s;
  logic             busy_next_s;

  // At or past the limit. The >= guarantees count never exceeds the limit
  // in RUN, so the counter can never overflow.
  logic             at_limit_s;

  assign at_limit_s = (count_r >= limit_r);

  // Next-state and next-output decode; everything holds by default.
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    limit_next_s = limit_r;
    done_next_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          // Latch a fresh limit. A held count above the new limit would
          // otherwise sit outside the legal range, so clear it.
          limit_next_s = bus.load;
          state_next_s = ST_RUN;
          if (count_r > bus.load) begin
            count_next_s = ZERO;
          end else begin
            count_next_s = count_r;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (bus.start) begin
          if (at_limit_s) begin
            done_next_s = 1'b1;
`ifdef UPCOUNTER_ONESHOT_EN
            // One-shot: park at the limit until start is released.
            count_next_s = limit_r;
            state_next_s = ST_HALT;
`else
            // Periodic wrap; the period is limit + 1 cycles.
            count_next_s = ZERO;
            state_next_s = ST_RUN;
`endif
          end else begin
            count_next_s = count_r + ONE;
            state_next_s = ST_RUN;
          end
        end else begin
          // Pause: keep the count and wait for the next start.
          state_next_s = ST_IDLE;
        end
      end

`ifdef UPCOUNTER_ONESHOT_EN
      ST_HALT: begin
        if (bus.start) begin
          state_next_s = ST_HALT;
        end else begin
          // Re-arm requires start low then high; the low phase clears count.
          state_next_s = ST_IDLE;
          count_next_s = ZERO;
        end
      end
`endif

      default: begin
        // Unreachable encodings recover to a clean idle state.
        state_next_s = ST_IDLE;
        count_next_s = ZERO;
        limit_next_s = ZERO;
      end
    endcase

    busy_next_s = (state_next_s == ST_RUN);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r <= ST_IDLE;
      count_r <= ZERO;
      limit_r <= ZERO;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
      limit_r <= limit_next_s;
      done_r  <= done_next_s;
      busy_r  <= busy_next_s;
    end
  end

  assign bus.count = count_r;
  assign bus.done  = done_r;
  assign bus.busy  = busy_r;

endmodule

// File: tb/tb_up_counter.sv
// tb_up_counter: directed self-checking bench for up_counter.
// Expected values are computed by hand from the counter's documented timing.
// Define UPCOUNTER_ONESHOT_EN to exercise the one-shot build.
module tb_up_counter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  up_counter_if #(.WIDTH(32'd16)) bus ();

  up_counter #(.WIDTH(32'd16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 unit past the last edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic expect_out(input string tag, input int c, input int d, input int b);
    check({tag, ".count"}, 32'(bus.count), 32'(c));
    check({tag, ".done"},  32'(bus.done),  32'(d));
    check({tag, ".busy"},  32'(bus.busy),  32'(b));
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b1;
    bus.start = 1'b0;
    bus.load  = 16'd0;

    // Reset state.
    step(2);
    rst_n = 1'b0;
    expect_out("reset", 0, 0, 0);

`ifndef UPCOUNTER_ONESHOT_EN
    // Count up with a large limit: after edge i, count = i-1.
    bus.load  = 16'd1000;
    bus.start = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      step(1);
      expect_out("run1000", i - 1, 0, 1);
    end

    // Long pause: count holds at 49.
    bus.start = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      step(1);
      expect_out("pause", 49, 0, 0);
    end

    // Limit 3: resume clears 49 -> 0, then period of 4 with done on wrap.
    bus.load  = 16'd3;
    bus.start = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      step(1);
      expect_out("lim3", (n - 1) % 4, ((n >= 5) && (((n - 1) % 4) == 0)) ? 1 : 0, 1);
    end

    // Limit 0: count pinned at 0, done every RUN cycle after entry.
    bus.start = 1'b0;
    step(1);
    expect_out("lim0_pause", 0, 0, 0);
    bus.load  = 16'd0;
    bus.start = 1'b1;
    step(1);
    expect_out("lim0_enter", 0, 0, 1);
    for (int n = 0; n < 7; n++) begin
      step(1);
      expect_out("lim0_run", 0, 1, 1);
    end

    // Load changed mid-run is ignored until resume.
    bus.start = 1'b0;
    step(1);
    expect_out("ld_pause", 0, 0, 0);
    bus.load  = 16'd10;
    bus.start = 1'b1;
    step(4);
    expect_out("ld_run", 3, 0, 1);
    bus.load = 16'd2;
    step(2);
    expect_out("ld_ignored", 5, 0, 1);
    bus.start = 1'b0;
    step(1);
    expect_out("ld_held", 5, 0, 0);
    bus.start = 1'b1;
    step(1);
    expect_out("ld_clear", 0, 0, 1);
    step(1);
    expect_out("ld_c1", 1, 0, 1);
    step(1);
    expect_out("ld_c2", 2, 0, 1);
    step(1);
    expect_out("ld_wrap", 0, 1, 1);

    // Reset mid-count at count = 7.
    bus.start = 1'b0;
    step(1);
    expect_out("rst_pause", 0, 0, 0);
    bus.load  = 16'd20;
    bus.start = 1'b1;
    step(8);
    expect_out("rst_pre", 7, 0, 1);
    rst_n = 1'b1;
    step(1);
    expect_out("rst_mid", 0, 0, 0);
    rst_n = 1'b0;
    step(1);
    expect_out("rst_reenter", 0, 0, 1);
    step(1);
    expect_out("rst_count", 1, 0, 1);
`else
    // One-shot with limit 5: count 0..5, then done once and HALT.
    bus.load  = 16'd5;
    bus.start = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      expect_out("os_run", i - 1, 0, 1);
    end
    step(1);
    expect_out("os_done", 5, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      expect_out("os_halt", 5, 0, 0);
    end
    bus.start = 1'b0;
    step(1);
    expect_out("os_idle", 0, 0, 0);
    step(1);
    expect_out("os_idle2", 0, 0, 0);
    bus.start = 1'b1;
    step(1);
    expect_out("os_rearm", 0, 0, 1);
    step(1);
    expect_out("os_restart", 1, 0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
